// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encoding and nibble width.
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_adder.sv
// Combinational 4-bit adder core with carry in/out; one nibble per clock in the serial adder.
module nibble_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       carry_in,
  output logic [3:0] sum,
  output logic       carry_out
);

  logic [4:0] w_total;

  // Zero-extend everything to 5 bits so the carry lands in bit 4.
  assign w_total   = {1'b0, a} + {1'b0, b} + {4'b0000, carry_in};
  assign sum       = w_total[3:0];
  assign carry_out = w_total[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle adder: {carry_out,sum} = a + b + carry_in, processed one nibble per clock.
// Operands are captured on an accepted start; the result register only updates on completion.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_carry_out;
  logic [IDX_W-1:0] r_idx;

  logic [3:0]       w_core_sum;
  logic             w_core_carry;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_sum_sh_next;

  nibble_adder u_core (
    .a         (r_a_sh[3:0]),
    .b         (r_b_sh[3:0]),
    .carry_in  (r_carry),
    .sum       (w_core_sum),
    .carry_out (w_core_carry)
  );

  // Start is only honoured when no operation is in flight.
  assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last   = (r_idx == IDX_W'(NIBBLES - 1));

  // New nibble enters at the MSB end; after NIBBLES shifts nibble 0 sits at the bottom.
  assign w_sum_sh_next = (r_sum_sh >> NIBBLE_W) | (WIDTH'(w_core_sum) << (WIDTH - NIBBLE_W));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode; DONE lasts one cycle and may chain straight into RUN.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = RUN;
      RUN:     if (w_last) w_state_next = DONE;
      DONE:    w_state_next = start ? RUN : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Operand load, per-nibble shift/carry update, and result capture on the last nibble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_sum_sh    <= '0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_sum       <= '0;
      r_carry_out <= 1'b0;
    end else if (w_accept) begin
      r_a_sh  <= a;
      r_b_sh  <= b;
      r_carry <= carry_in;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_a_sh   <= r_a_sh >> NIBBLE_W;
      r_b_sh   <= r_b_sh >> NIBBLE_W;
      r_sum_sh <= w_sum_sh_next;
      r_carry  <= w_core_carry;
      r_idx    <= r_idx + IDX_W'(1);
      if (w_last) begin
        r_sum       <= w_sum_sh_next;
        r_carry_out <= w_core_carry;
      end
    end
  end

  assign busy      = (r_state == RUN);
  assign done      = (r_state == DONE);
  assign sum       = r_sum;
  assign carry_out = r_carry_out;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder: 16-bit and 4-bit instances side by side.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start16 = 1'b0;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;
  logic        cin16 = 1'b0;
  logic        busy16, done16, cout16;
  logic [15:0] sum16;

  logic        start4 = 1'b0;
  logic [3:0]  a4 = '0;
  logic [3:0]  b4 = '0;
  logic        cin4 = 1'b0;
  logic        busy4, done4, cout4;
  logic [3:0]  sum4;

  logic [16:0] q16[$];
  logic [4:0]  q4[$];
  logic [16:0] hold16 = '0;
  logic [4:0]  hold4 = '0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .carry_in(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .carry_out(cout16)
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .carry_in(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .carry_out(cout4)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops expectations on done, and checks the held result never moves during RUN.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold16 = '0;
      hold4  = '0;
    end else begin
      if (done16) begin
        if (q16.size() == 0) chk("dut16 unexpected done", 32'(done16), 32'd0);
        else begin
          hold16 = q16.pop_front();
          chk("dut16 result", 32'({cout16, sum16}), 32'(hold16));
        end
      end else if (busy16) begin
        chk("dut16 held during run", 32'({cout16, sum16}), 32'(hold16));
      end
      if (done4) begin
        if (q4.size() == 0) chk("dut4 unexpected done", 32'(done4), 32'd0);
        else begin
          hold4 = q4.pop_front();
          chk("dut4 result", 32'({cout4, sum4}), 32'(hold4));
        end
      end else if (busy4) begin
        chk("dut4 held during run", 32'({cout4, sum4}), 32'(hold4));
      end
    end
  end

  task automatic issue(input bit sel4, input logic [15:0] av, input logic [15:0] bv,
                       input logic cv, input bit push, input logic [16:0] exp);
    @(negedge clk);
    if (sel4) begin
      a4 = av[3:0]; b4 = bv[3:0]; cin4 = cv; start4 = 1'b1;
      if (push) q4.push_back(exp[4:0]);
    end else begin
      a16 = av; b16 = bv; cin16 = cv; start16 = 1'b1;
      if (push) q16.push_back(exp);
    end
  endtask

  task automatic wait_done(input bit sel4, input bit keep, input int pulse_at,
                           input int exp_busy, input string nm);
    int  bc = 0;
    bit  seen = 1'b0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      if (i == 1 && !keep) begin start16 = 1'b0; start4 = 1'b0; end
      if (pulse_at != 0 && i == pulse_at) begin start16 = 1'b1; a16 = 16'hAAAA; b16 = 16'h5555; end
      if (pulse_at != 0 && i == pulse_at + 1) begin start16 = 1'b0; a16 = 16'h0000; b16 = 16'h0000; end
      if (sel4 ? done4 : done16) seen = 1'b1;
      else if (sel4 ? busy4 : busy16) bc++;
    end
    chk({nm, " done seen"}, 32'(seen), 32'd1);
    chk({nm, " busy cycles"}, 32'(bc), 32'(exp_busy));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int dcount;
    // Reset state
    repeat (2) @(negedge clk);
    chk("reset sum16", 32'(sum16), 32'd0);
    chk("reset cout16", 32'(cout16), 32'd0);
    chk("reset busy16", 32'(busy16), 32'd0);
    chk("reset done16", 32'(done16), 32'd0);
    chk("reset sum4/cout4", 32'({cout4, sum4}), 32'd0);
    rst_n = 1'b1;

    // 1: basic add
    issue(0, 16'h1234, 16'h4321, 1'b0, 1, 17'h05555);
    wait_done(0, 0, 0, 4, "t1");

    // 2: carry ripples through every nibble
    issue(0, 16'hFFFF, 16'h0001, 1'b0, 1, 17'h10000);
    wait_done(0, 0, 0, 4, "t2");

    // 3: all ones plus carry-in, then back-to-back start held through DONE
    issue(0, 16'hFFFF, 16'hFFFF, 1'b1, 1, 17'h1FFFF);
    wait_done(0, 1, 0, 4, "t3a");
    a16 = 16'h0001; b16 = 16'h0002; cin16 = 1'b0;
    q16.push_back(17'h00003);
    wait_done(0, 0, 0, 4, "t3b");

    // 4: start pulse during RUN is ignored
    issue(0, 16'h00F0, 16'h0010, 1'b0, 1, 17'h00100);
    wait_done(0, 0, 2, 4, "t4");

    // 5: reset in the second RUN cycle aborts the operation
    issue(0, 16'h1234, 16'h1111, 1'b0, 0, 17'h0);
    @(negedge clk); start16 = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("abort sum16", 32'(sum16), 32'd0);
    chk("abort cout16", 32'(cout16), 32'd0);
    chk("abort busy16", 32'(busy16), 32'd0);
    chk("abort done16", 32'(done16), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done16 || busy16) dcount++;
    end
    chk("abort no activity", 32'(dcount), 32'd0);
    issue(0, 16'h8000, 16'h8000, 1'b0, 1, 17'h10000);
    wait_done(0, 0, 0, 4, "t5");

    // 6: single-nibble instance completes on the first RUN edge
    issue(1, 16'h0009, 16'h0008, 1'b1, 1, 17'h00012);
    wait_done(1, 0, 0, 1, "t6");

    repeat (3) @(negedge clk);
    chk("q16 drained", 32'(q16.size()), 32'd0);
    chk("q4 drained", 32'(q4.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
